// File: rtl/mem_resp8_if.sv
// Request/response bus between the pipeline memory stage and mem_resp8,
// plus the 8-bit external SRAM-style bus driven by the responder.
interface mem_resp8_if;
    logic [15:0] mem_addr_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic        mem_word_i;
    logic [15:0] mem_data_i;
    logic [15:0] mem_data_o;
    logic        mem_ready_o;
    logic [15:0] ext_addr_o;
    logic [7:0]  ext_data_o;
    logic [7:0]  ext_data_i;
    logic        ext_oe_o;
    logic        ext_we_o;

    // Responder side (the design itself).
    modport slave (
        input  mem_addr_i, mem_re_i, mem_we_i, mem_word_i, mem_data_i, ext_data_i,
        output mem_data_o, mem_ready_o, ext_addr_o, ext_data_o, ext_oe_o, ext_we_o
    );

    // Requester and external memory side.
    modport master (
        output mem_addr_i, mem_re_i, mem_we_i, mem_word_i, mem_data_i, ext_data_i,
        input  mem_data_o, mem_ready_o, ext_addr_o, ext_data_o, ext_oe_o, ext_we_o
    );
endinterface

// File: rtl/mem_resp8.sv
// Memory responder: turns 16-bit byte/word requests into one or two big-endian
// 8-bit external bus phases with WAIT_STATES extra cycles per phase.
module mem_resp8 #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_resp8_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

    localparam logic [3:0] WAIT_RELOAD = 4'(WAIT_STATES);

    state_t      state_q,    state_d;
    logic [3:0]  wait_q,     wait_d;
    logic        is_word_q,  is_word_d;
    logic        is_write_q, is_write_d;
    logic [7:0]  wlo_q,      wlo_d;
    logic [7:0]  rhi_q,      rhi_d;
    logic [15:0] mem_data_q, mem_data_d;
    logic        ready_q,    ready_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_data_q, ext_data_d;
    logic        ext_oe_q,   ext_oe_d;
    logic        ext_we_q,   ext_we_d;

    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        is_word_d  = is_word_q;
        is_write_d = is_write_q;
        wlo_d      = wlo_q;
        rhi_d      = rhi_q;
        mem_data_d = mem_data_q;
        ready_d    = 1'b0;
        ext_addr_d = ext_addr_q;
        ext_data_d = ext_data_q;
        ext_oe_d   = ext_oe_q;
        ext_we_d   = ext_we_q;

        unique case (state_q)
            IDLE: begin
                if (bus.mem_we_i || bus.mem_re_i) begin
                    // A simultaneous read and write request is treated as a write.
                    is_write_d = bus.mem_we_i;
                    is_word_d  = bus.mem_word_i;
                    wlo_d      = bus.mem_data_i[7:0];
                    ext_addr_d = bus.mem_word_i ? {bus.mem_addr_i[15:1], 1'b0} : bus.mem_addr_i;
                    ext_data_d = bus.mem_word_i ? bus.mem_data_i[15:8] : bus.mem_data_i[7:0];
                    ext_we_d   = bus.mem_we_i;
                    ext_oe_d   = !bus.mem_we_i;
                    wait_d     = WAIT_RELOAD;
                    state_d    = BYTE0;
                end
            end
            BYTE0: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (is_word_q) begin
                    rhi_d      = bus.ext_data_i;
                    ext_addr_d = {ext_addr_q[15:1], 1'b1};
                    ext_data_d = wlo_q;
                    wait_d     = WAIT_RELOAD;
                    state_d    = BYTE1;
                end else begin
                    if (!is_write_q) begin
                        // Byte reads land in their big-endian lane.
                        mem_data_d = ext_addr_q[0] ? {8'h00, bus.ext_data_i}
                                                   : {bus.ext_data_i, 8'h00};
                    end
                    ext_oe_d = 1'b0;
                    ext_we_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            BYTE1: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    if (!is_write_q) begin
                        mem_data_d = {rhi_q, bus.ext_data_i};
                    end
                    ext_oe_d = 1'b0;
                    ext_we_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= 4'd0;
            is_word_q  <= 1'b0;
            is_write_q <= 1'b0;
            wlo_q      <= 8'h00;
            rhi_q      <= 8'h00;
            mem_data_q <= 16'h0000;
            ready_q    <= 1'b0;
            ext_addr_q <= 16'h0000;
            ext_data_q <= 8'h00;
            ext_oe_q   <= 1'b0;
            ext_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            is_word_q  <= is_word_d;
            is_write_q <= is_write_d;
            wlo_q      <= wlo_d;
            rhi_q      <= rhi_d;
            mem_data_q <= mem_data_d;
            ready_q    <= ready_d;
            ext_addr_q <= ext_addr_d;
            ext_data_q <= ext_data_d;
            ext_oe_q   <= ext_oe_d;
            ext_we_q   <= ext_we_d;
        end
    end

    assign bus.mem_data_o  = mem_data_q;
    assign bus.mem_ready_o = ready_q;
    assign bus.ext_addr_o  = ext_addr_q;
    assign bus.ext_data_o  = ext_data_q;
    assign bus.ext_oe_o    = ext_oe_q;
    assign bus.ext_we_o    = ext_we_q;
endmodule
